seg7_bcd_display: RTL
=====================

# seg7_bcd_display

Downstream display stage for the Fibonacci datapath: accepts a 16-bit register value selected by the controller's final display state, converts it to four decimal digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a 4-digit common-anode 7-segment display. Conversion and refresh run concurrently. The shown value changes atomically once a conversion completes.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20-1.
- clk  in  1  rising-edge system clock.
- clr  in  1  synchronous, active-low reset.
- value  in  16  unsigned binary value to display.
- load  in  1  single-cycle request to convert `value`.
- busy  out  1  high while a conversion is in progress.
- ovf  out  1  high when the displayed value exceeds 9999.
- an  out  4  digit enables, active-low; an[0] is the least significant digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; always 1.

## Operation
- Conversion FSM states:
  - IDLE: busy=0. When load=1, capture `value` into the shift register, clear the 20-bit BCD accumulator and 4-bit counter, and go to CONV.
  - CONV: 16 cycles. Each cycle:
    - add 3 to every BCD nibble that is ≥5;
    - shift {bcd, shreg} left by 1;
    - increment the counter.
    - After the 16th shift, go to LATCH.
  - LATCH: copy the low 16 BCD bits to the display register. Set ovf = (bcd[19:16] != 0). Go to IDLE.
- load while busy=1 is ignored and not queued.
- Refresh:
  - A 20-bit counter counts 0..REFRESH_DIV-1. On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - Register an and seg from the current index.
- Decoding:
  - Digits 0-9 use standard patterns, e.g. 0 = 1000000, 1 = 1111001, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Nibbles above 9 cannot occur.
  - When ovf=1, every digit shows a dash (0111111).
- Refresh never stalls during conversion; the old value stays displayed until LATCH.

## Timing
- Reset (clr=0 at an edge) sets:
  - FSM to IDLE; busy=0, ovf=0;
  - display register 0, refresh counter 0, digit index 0;
  - an=1111, seg=1111111, dp=1.
- Load latency:
  - load sampled at edge E0 → busy=1 after E0.
  - Shifts occur at E1..E16; LATCH executes at E17.
  - busy=0 and the new display register are valid after E17, so busy is high for exactly 17 cycles.
  - load may be reasserted at E18.
- Refresh:
  - an first becomes 1110 after edge REFRESH_DIV following reset.
  - Each digit is then enabled for exactly REFRESH_DIV cycles.
  - an and seg change on the same edge, so there are no mixed-digit glitches.
- Value 0 yields 0000, or 0 when blanking is enabled.
- Reset mid-conversion aborts the conversion. Display and ovf are cleared, and no partial result is ever latched.
- load and clr both active at one edge: reset wins.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN:
  - Defined: a zero digit above the most significant nonzero digit drives seg=1111111 while its an remains asserted. Digit 0 is never blanked. Blanking is suppressed when ovf=1 (dashes shown).
  - Undefined: all four digits are always shown, including leading zeros.

## Test plan
- Reset then idle, REFRESH_DIV=4:
  - an stays 1111 for 4 cycles after reset, then cycles 1110,1101,1011,0111, 4 cycles each.
  - seg=1000000 on every digit without the macro.
- load value=987:
  - busy high exactly 17 cycles.
  - Digits 3..0 show 0,9,8,7 (seg 1000000,0010000,0000000,1111000); ovf=0.
- load value=10000:
  - ovf=1 after LATCH; all four digits show 0111111.
  - A following load of 610 clears ovf and shows 0610.
- load 144, then pulse load with 233 at cycle 5 of busy:
  - The second request is ignored; the display shows 0144; busy drops at cycle 17.
- Assert clr=0 at cycle 8 of a conversion of 377:
  - busy=0, ovf=0, and outputs take their reset values next cycle.
  - The display shows 0 after scanning resumes.
- With SEG7_LEADING_ZERO_BLANK_EN defined, load 5:
  - Digits 3..1 have seg=1111111 and digit 0 shows 0010010.
  - Load 0 shows a single 0 on digit 0.

Source files
------------

// File: rtl/seg7_bcd_display.sv
// 16-bit binary to 4-digit BCD (sequential double-dabble) with multiplexed common-anode 7-segment drive.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_bcd_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LATCH
  } state_t;

  state_t      r_state;
  logic [15:0] r_shreg;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [15:0] r_disp;
  logic        r_ovf;
  logic        r_busy;

  logic [19:0] r_rcnt;
  logic [1:0]  r_idx;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;

  logic [19:0] w_adj;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_next;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_disp  <= '0;
      r_shreg <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shreg <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd, r_shreg} <= {w_adj[18:0], r_shreg, 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_disp  <= r_bcd[15:0];
          r_ovf   <= |r_bcd[19:16];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wrap = (r_rcnt == 20'(REFRESH_DIV - 1));

  always_comb begin
    w_nib   = r_disp[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_nib = r_disp[7:4];
      2'd2:    w_nib = r_disp[11:8];
      2'd3:    w_nib = r_disp[15:12];
      default: w_nib = r_disp[3:0];
    endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (r_idx)
      2'd1:    w_blank = (r_disp[15:4] == 12'd0);
      2'd2:    w_blank = (r_disp[15:8] == 8'd0);
      2'd3:    w_blank = (r_disp[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
`endif
    if (r_ovf)        w_seg_next = 7'b0111111;
    else if (w_blank) w_seg_next = 7'b1111111;
    else              w_seg_next = f_decode(w_nib);
  end

  // an and seg are loaded together only at a refresh wrap, so a new latch never tears a digit
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_rcnt <= '0;
      r_idx  <= '0;
      r_an   <= 4'b1111;
      r_seg  <= 7'b1111111;
    end else begin
      r_rcnt <= w_wrap ? '0 : (r_rcnt + 20'd1);
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_seg_next;
      end
    end
  end

  assign busy = r_busy;
  assign ovf  = r_ovf;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;

endmodule
